// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write arbiter and its pending queue.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int PTR_W     = $clog2(WB_DEPTH);

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rdc;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_queue.sv
// Circular buffer of MDU results with per-entry valid, squash-by-address, head discard
// and youngest-match lookup (lookup present only when WB_FWD_EN is defined).
module wb_pending_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WB_ADDR_W-1:0] push_rdc_i,
  input  logic [WB_DATA_W-1:0] push_data_i,
  input  logic                 squash_i,
  input  logic [WB_ADDR_W-1:0] squash_rdc_i,
  input  logic                 pop_i,
  output logic                 head_valid_o,
  output logic [WB_ADDR_W-1:0] head_rdc_o,
  output logic [WB_DATA_W-1:0] head_data_o,
  output logic                 busy_o,
  output logic                 full_o,
  input  logic [WB_ADDR_W-1:0] lk_a_i,
  input  logic [WB_ADDR_W-1:0] lk_b_i,
  output logic                 lk_a_hit_o,
  output logic [WB_DATA_W-1:0] lk_a_o,
  output logic                 lk_b_hit_o,
  output logic [WB_DATA_W-1:0] lk_b_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t         ents_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [PW:0]       count_q, count_d;
  logic              head_adv;

  assign busy_o       = (count_q != '0);
  assign full_o       = (count_q == (PW+1)'(DEPTH));
  assign head_valid_o = busy_o && ents_q[head_q].valid;
  assign head_rdc_o   = ents_q[head_q].rdc;
  assign head_data_o  = ents_q[head_q].data;

  // A squashed (invalid) occupied head is dropped even when the port is busy.
  assign head_adv = busy_o && (!ents_q[head_q].valid || pop_i);

  always_comb begin
    count_d = count_q;
    if (push_i && !head_adv)      count_d = count_q + 1'b1;
    else if (!push_i && head_adv) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ents_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash_i && ents_q[i].rdc == squash_rdc_i) ents_q[i].valid <= 1'b0;
      // Freed slots drop their valid so the lookup only ever sees occupied entries.
      if (head_adv) begin
        ents_q[head_q].valid <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      if (push_i) begin
        ents_q[tail_q] <= '{valid: 1'b1, rdc: push_rdc_i, data: push_data_i};
        tail_q <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

`ifdef WB_FWD_EN
  // Oldest-to-youngest scan; a later match overrides so the youngest wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    lk_a_hit_o = 1'b0;
    lk_a_o     = '0;
    lk_b_hit_o = 1'b0;
    lk_b_o     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (ents_q[idx].valid && lk_a_i != REG_ZERO && ents_q[idx].rdc == lk_a_i) begin
        lk_a_hit_o = 1'b1;
        lk_a_o     = ents_q[idx].data;
      end
      if (ents_q[idx].valid && lk_b_i != REG_ZERO && ents_q[idx].rdc == lk_b_i) begin
        lk_b_hit_o = 1'b1;
        lk_b_o     = ents_q[idx].data;
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk  = ^{lk_a_i, lk_b_i};
  assign lk_a_hit_o = 1'b0;
  assign lk_a_o     = '0;
  assign lk_b_hit_o = 1'b0;
  assign lk_b_o     = '0;
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port owner: pipeline writebacks win, MDU results queue behind them.
// Optional forwarding lookup into the queue is enabled by defining WB_FWD_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_rdc_i,
  input  logic [DATA_W-1:0] pipe_rd_i,
  input  logic              mdu_valid_i,
  input  logic [ADDR_W-1:0] mdu_rdc_i,
  input  logic [DATA_W-1:0] mdu_rd_i,
  output logic              mdu_ready_o,
  output logic              RF_w_o,
  output logic [ADDR_W-1:0] rdc_o,
  output logic [DATA_W-1:0] rd_o,
  output logic              q_busy_o,
  input  logic [ADDR_W-1:0] fwd_rsc_i,
  input  logic [ADDR_W-1:0] fwd_rtc_i,
  output logic              fwd_rs_hit_o,
  output logic [DATA_W-1:0] fwd_rs_o,
  output logic              fwd_rt_hit_o,
  output logic [DATA_W-1:0] fwd_rt_o
);

  logic              pipe_eff, mdu_acc, enq, full, head_valid;
  logic [ADDR_W-1:0] head_rdc;
  logic [DATA_W-1:0] head_data;
  logic              rf_w_q, rf_w_d;
  logic [ADDR_W-1:0] rdc_q, rdc_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  assign pipe_eff    = pipe_we_i && (pipe_rdc_i != REG_ZERO);
  assign mdu_ready_o = !full;
  assign mdu_acc     = mdu_valid_i && mdu_ready_o;
  // A same-cycle pipe write to the same register supersedes the older MDU result.
  assign enq = mdu_acc && (mdu_rdc_i != REG_ZERO) &&
               !(pipe_eff && (mdu_rdc_i == pipe_rdc_i));

  wb_pending_queue #(.DEPTH(DEPTH)) u_q (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (enq),
    .push_rdc_i   (mdu_rdc_i),
    .push_data_i  (mdu_rd_i),
    .squash_i     (pipe_eff),
    .squash_rdc_i (pipe_rdc_i),
    .pop_i        (!pipe_eff && head_valid),
    .head_valid_o (head_valid),
    .head_rdc_o   (head_rdc),
    .head_data_o  (head_data),
    .busy_o       (q_busy_o),
    .full_o       (full),
    .lk_a_i       (fwd_rsc_i),
    .lk_b_i       (fwd_rtc_i),
    .lk_a_hit_o   (fwd_rs_hit_o),
    .lk_a_o       (fwd_rs_o),
    .lk_b_hit_o   (fwd_rt_hit_o),
    .lk_b_o       (fwd_rt_o)
  );

  always_comb begin
    rf_w_d = 1'b0;
    rdc_d  = rdc_q;
    rd_d   = rd_q;
    if (pipe_eff) begin
      rf_w_d = 1'b1;
      rdc_d  = pipe_rdc_i;
      rd_d   = pipe_rd_i;
    end else if (head_valid) begin
      rf_w_d = 1'b1;
      rdc_d  = head_rdc;
      rd_d   = head_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_w_q <= 1'b0;
      rdc_q  <= '0;
      rd_q   <= '0;
    end else begin
      rf_w_q <= rf_w_d;
      rdc_q  <= rdc_d;
      rd_q   <= rd_d;
    end
  end

  assign RF_w_o = rf_w_q;
  assign rdc_o  = rdc_q;
  assign rd_o   = rd_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (default build; WB_FWD_EN expectations guarded).
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, mdu_valid, mdu_ready, rf_w, q_busy;
  logic [4:0]  pipe_rdc, mdu_rdc, rdc, fwd_rsc, fwd_rtc;
  logic [31:0] pipe_rd, mdu_rd, rd, fwd_rs, fwd_rt;
  logic        fwd_rs_hit, fwd_rt_hit;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_we_i(pipe_we), .pipe_rdc_i(pipe_rdc), .pipe_rd_i(pipe_rd),
    .mdu_valid_i(mdu_valid), .mdu_rdc_i(mdu_rdc), .mdu_rd_i(mdu_rd),
    .mdu_ready_o(mdu_ready), .RF_w_o(rf_w), .rdc_o(rdc), .rd_o(rd),
    .q_busy_o(q_busy), .fwd_rsc_i(fwd_rsc), .fwd_rtc_i(fwd_rtc),
    .fwd_rs_hit_o(fwd_rs_hit), .fwd_rs_o(fwd_rs),
    .fwd_rt_hit_o(fwd_rt_hit), .fwd_rt_o(fwd_rt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pipe_we = 0; pipe_rdc = 0; pipe_rd = 0;
    mdu_valid = 0; mdu_rdc = 0; mdu_rd = 0; fwd_rsc = 0; fwd_rtc = 0;
    tick(); tick();
    chk("rst_rfw", rf_w, 0);
    chk("rst_rdc", rdc, 0);
    chk("rst_rd", rd, 0);
    chk("rst_busy", q_busy, 0);
    chk("rst_ready", mdu_ready, 1);
    rst = 1'b0;

    // 1: pipeline write, latency 1
    pipe_we = 1; pipe_rdc = 3; pipe_rd = 32'hA5;
    tick();
    pipe_we = 0;
    chk("t1_rfw", rf_w, 1);
    chk("t1_rdc", rdc, 3);
    chk("t1_rd", rd, 32'hA5);
    chk("t1_busy", q_busy, 0);
    tick();
    chk("t1_idle", rf_w, 0);

    // 2: MDU push, write visible two cycles later
    mdu_valid = 1; mdu_rdc = 7; mdu_rd = 32'h1234;
    tick();
    mdu_valid = 0;
    chk("t2_rfw_n1", rf_w, 0);
    chk("t2_busy", q_busy, 1);
    tick();
    chk("t2_rfw", rf_w, 1);
    chk("t2_rdc", rdc, 7);
    chk("t2_rd", rd, 32'h1234);
    chk("t2_busy_after", q_busy, 0);

    // 3: pipe holds the port for 6 cycles while MDU fills the queue
    for (int c = 0; c < 6; c++) begin
      pipe_we = 1; pipe_rdc = 1; pipe_rd = 32'h100 + c;
      mdu_valid = 1;
      mdu_rdc = (c < 4) ? 5'(8 + c) : 5'd12;
      mdu_rd  = (c < 4) ? 32'h800 + c : 32'h804;
      chk("t3_ready", mdu_ready, (c < 4) ? 1 : 0);
      tick();
      chk("t3_pipe_rd", rd, 32'h100 + c);
    end
    pipe_we = 0;
    chk("t3_full", mdu_ready, 0);
    tick();
    chk("t3_pop0_rdc", rdc, 8);
    chk("t3_pop0_rd", rd, 32'h800);
    chk("t3_ready_again", mdu_ready, 1);
    tick();
    mdu_valid = 0;
    chk("t3_pop1", rdc, 9);
    tick();
    chk("t3_pop2", rdc, 10);
    tick();
    chk("t3_pop3", rdc, 11);
    tick();
    chk("t3_pop4_rdc", rdc, 12);
    chk("t3_pop4_rd", rd, 32'h804);
    chk("t3_pop4_w", rf_w, 1);
    tick();
    chk("t3_drained_w", rf_w, 0);
    chk("t3_drained_busy", q_busy, 0);

    // 4: queued r5 squashed by a younger pipe write to r5
    mdu_valid = 1; mdu_rdc = 5; mdu_rd = 32'h11;
    tick();
    mdu_valid = 0;
    chk("t4_queued_w", rf_w, 0);
    fwd_rsc = 5;
    #1;
`ifdef WB_FWD_EN
    chk("t4_fwd_hit", fwd_rs_hit, 1);
    chk("t4_fwd_data", fwd_rs, 32'h11);
`else
    chk("t4_fwd_hit", fwd_rs_hit, 0);
    chk("t4_fwd_data", fwd_rs, 0);
`endif
    fwd_rsc = 0;
    pipe_we = 1; pipe_rdc = 5; pipe_rd = 32'h22;
    tick();
    pipe_we = 0;
    chk("t4_pipe_rd", rd, 32'h22);
    chk("t4_squash_busy", q_busy, 1);
    tick();
    chk("t4_no_stale", rf_w, 0);
    chk("t4_discard", q_busy, 0);
    tick();
    chk("t4_still_idle", rf_w, 0);

    // same-cycle pipe and MDU writes to r6: MDU result dropped
    pipe_we = 1; pipe_rdc = 6; pipe_rd = 32'h66;
    mdu_valid = 1; mdu_rdc = 6; mdu_rd = 32'h77;
    tick();
    pipe_we = 0; mdu_valid = 0;
    chk("t4b_rd", rd, 32'h66);
    chk("t4b_busy", q_busy, 0);
    tick();
    chk("t4b_idle", rf_w, 0);

    // 5: r0 requests ignored
    pipe_we = 1; pipe_rdc = 0; pipe_rd = 32'hFF;
    mdu_valid = 1; mdu_rdc = 0; mdu_rd = 32'hEE;
    tick();
    pipe_we = 0; mdu_valid = 0;
    chk("t5_rfw", rf_w, 0);
    chk("t5_busy", q_busy, 0);
    chk("t5_ready", mdu_ready, 1);

    // 6: reset with 3 entries queued
    for (int c = 0; c < 3; c++) begin
      pipe_we = 1; pipe_rdc = 1; pipe_rd = 32'h200 + c;
      mdu_valid = 1; mdu_rdc = 5'(20 + c); mdu_rd = 32'h900 + c;
      tick();
    end
    pipe_we = 0; mdu_valid = 0;
    chk("t6_busy_pre", q_busy, 1);
    rst = 1;
    tick();
    chk("t6_rst_w", rf_w, 0);
    chk("t6_rst_busy", q_busy, 0);
    chk("t6_rst_ready", mdu_ready, 1);
    rst = 0;
    tick();
    chk("t6_no_stale0", rf_w, 0);
    tick();
    chk("t6_no_stale1", rf_w, 0);
    chk("t6_busy_post", q_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
